// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite RAM slave: response codes and
// the write-channel state encoding.
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
  localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;

  // W_HAVE_AW / W_HAVE_W record which half of a write is parked in the holding registers.
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

endpackage

// File: rtl/axil_ram_slave_if.sv
// AXI-Lite bundle between the bridge (master) and the RAM endpoint (slave).
// The bundle carries the five channels only; clock and reset stay module ports.
interface axil_ram_slave_if
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  axil_resp_t            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  axil_resp_t            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_ram_array.sv
// Word-wide synchronous RAM built from one byte-wide array per lane, with a
// byte-enabled write port and a registered read port returning pre-write data.
module axil_ram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      // Both accesses sit in one block, so a same-address read sees the old byte.
      always_ff @(posedge clk) begin
        if (we_i && wstrb_i[gi]) begin
          mem[waddr_i] <= wdata_i[gi*8 +: 8];
        end
        if (re_i) begin
          rd_q <= mem[raddr_i];
        end
      end

      assign rdata_o[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/axil_ram_slave.sv
// AXI-Lite slave endpoint backed by a byte-enable RAM. Independent write and
// read paths, one outstanding transaction each; out-of-range accesses get SLVERR.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int DEPTH           = 1024
) (
  input  logic             clk,
  input  logic             rst,
  axil_ram_slave_if.slave  s_axil
);

  localparam int ADDR_LSB = $clog2(AXIL_STRB_WIDTH);
  localparam int RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

  // Holds the readies low until the first edge after reset is released.
  logic en_q;

  wr_state_t                  wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0]      awaddr_q, awaddr_d;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXIL_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  axil_resp_t                 bresp_q, bresp_d;

  logic                       awready, wready, aw_hs, w_hs, wr_commit;
  logic [ADDR_WIDTH-1:0]      wr_addr, wr_word;
  logic [AXIL_DATA_WIDTH-1:0] wr_data;
  logic [AXIL_STRB_WIDTH-1:0] wr_strb;
  logic                       wr_in_range;

  logic                       rvalid_q, rvalid_d, rd_err_q, rd_err_d;
  logic                       arready, ar_hs, rd_in_range;
  logic [ADDR_WIDTH-1:0]      rd_word;
  logic [AXIL_DATA_WIDTH-1:0] ram_rdata;

  logic unused_prot;
  assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q       <= 1'b0;
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= AXIL_RESP_OKAY;
      rvalid_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      en_q       <= 1'b1;
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;

    awready = en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_W);
    wready  = en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_AW);
    aw_hs   = s_axil.awvalid && awready;
    w_hs    = s_axil.wvalid && wready;

    // Commit operands come from the holding register for whichever half arrived earlier.
    wr_addr     = (wr_state_q == W_HAVE_AW) ? awaddr_q : s_axil.awaddr;
    wr_data     = (wr_state_q == W_HAVE_W)  ? wdata_q  : s_axil.wdata;
    wr_strb     = (wr_state_q == W_HAVE_W)  ? wstrb_q  : s_axil.wstrb;
    wr_word     = wr_addr >> ADDR_LSB;
    wr_in_range = (wr_word < DEPTH_W);

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d   = s_axil.awaddr;
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d    = s_axil.wdata;
          wstrb_d    = s_axil.wstrb;
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: wr_commit = w_hs;
      W_HAVE_W:  wr_commit = aw_hs;
      W_RESP: begin
        if (s_axil.bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (wr_commit) begin
      wr_state_d = W_RESP;
      bresp_d    = wr_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end
  end

  always_comb begin
    arready     = en_q && (!rvalid_q || s_axil.rready);
    ar_hs       = s_axil.arvalid && arready;
    rd_word     = s_axil.araddr >> ADDR_LSB;
    rd_in_range = (rd_word < DEPTH_W);

    rvalid_d = rvalid_q;
    rd_err_d = rd_err_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rd_err_d = !rd_in_range;
    end else if (s_axil.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // The RAM read register only loads on an accepted in-range AR, so rdata holds while R stalls.
  axil_ram_array #(
    .DATA_WIDTH (AXIL_DATA_WIDTH),
    .STRB_WIDTH (AXIL_STRB_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_commit && wr_in_range),
    .waddr_i (wr_word[RAM_AW-1:0]),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .re_i    (ar_hs && rd_in_range),
    .raddr_i (rd_word[RAM_AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.bvalid  = (wr_state_q == W_RESP);
  assign s_axil.bresp   = (wr_state_q == W_RESP) ? bresp_q : AXIL_RESP_OKAY;
  assign s_axil.arready = arready;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = (rvalid_q && rd_err_q) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  assign s_axil.rdata   = (rvalid_q && !rd_err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed bench for axil_ram_slave: stimulus pushes expected B/R responses into
// queues, and negedge monitors pop and compare them on every handshake.
module tb_axil_ram_slave;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axil_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axil ();

  axil_ram_slave #(
    .ADDR_WIDTH      (32),
    .AXIL_DATA_WIDTH (32),
    .AXIL_STRB_WIDTH (4),
    .DEPTH           (1024)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (s_axil)
  );

  int checks   = 0;
  int failures = 0;

  logic [1:0]  b_q[$];
  logic [31:0] r_data_q[$];
  logic [1:0]  r_resp_q[$];
  logic [1:0]  b_exp;
  logic [31:0] r_exp_data;
  logic [1:0]  r_exp_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && s_axil.bvalid && s_axil.bready) begin
      if (b_q.size() == 0) begin
        chk("b_unexpected", 1, 0);
      end else begin
        b_exp = b_q.pop_front();
        $display("B   bresp=%0b expected=%0b", s_axil.bresp, b_exp);
        chk("bresp", s_axil.bresp, b_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && s_axil.rvalid && s_axil.rready) begin
      if (r_data_q.size() == 0) begin
        chk("r_unexpected", 1, 0);
      end else begin
        r_exp_data = r_data_q.pop_front();
        r_exp_resp = r_resp_q.pop_front();
        $display("R   rdata=0x%08h rresp=%0b expected 0x%08h/%0b",
                 s_axil.rdata, s_axil.rresp, r_exp_data, r_exp_resp);
        chk("rdata", s_axil.rdata, r_exp_data);
        chk("rresp", s_axil.rresp, r_exp_resp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // w_lead > 0 sends W alone and raises AW w_lead cycles after the W handshake.
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp,
                            input int w_lead);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int guard = 0;
    b_q.push_back(resp);
    $display("AW  addr=0x%08h data=0x%08h strb=%b lead=%0d", addr, data, strb, w_lead);
    s_axil.awaddr = addr;
    s_axil.wdata  = data;
    s_axil.wstrb  = strb;
    if (w_lead > 0) begin
      s_axil.wvalid = 1'b1;
      while (!w_done && guard < 20) begin
        @(negedge clk);
        w_now = s_axil.wvalid && s_axil.wready;
        tick();
        w_done = w_now;
        guard++;
      end
      s_axil.wvalid = 1'b0;
      for (int i = 1; i < w_lead; i++) begin
        chk("wready_low_after_capture", s_axil.wready, 0);
        chk("bvalid_waits_for_aw", s_axil.bvalid, 0);
        tick();
      end
    end
    s_axil.awvalid = 1'b1;
    s_axil.wvalid  = !w_done;
    guard = 0;
    while (!(aw_done && w_done) && guard < 20) begin
      @(negedge clk);
      aw_now = s_axil.awvalid && s_axil.awready;
      w_now  = s_axil.wvalid && s_axil.wready;
      tick();
      if (aw_now) begin aw_done = 1; s_axil.awvalid = 1'b0; end
      if (w_now)  begin w_done = 1;  s_axil.wvalid  = 1'b0; end
      guard++;
    end
    s_axil.awvalid = 1'b0;
    s_axil.wvalid  = 1'b0;
    chk("write_accepted", aw_done && w_done, 1);
    chk("bvalid_latency", s_axil.bvalid, 1);
  endtask

  task automatic axil_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input bit push);
    bit done = 0, now;
    int guard = 0;
    if (push) begin
      r_data_q.push_back(data);
      r_resp_q.push_back(resp);
    end
    $display("AR  addr=0x%08h", addr);
    s_axil.araddr  = addr;
    s_axil.arvalid = 1'b1;
    while (!done && guard < 20) begin
      @(negedge clk);
      now = s_axil.arvalid && s_axil.arready;
      tick();
      done = now;
      guard++;
    end
    s_axil.arvalid = 1'b0;
    chk("read_accepted", done, 1);
    chk("rvalid_latency", s_axil.rvalid, 1);
  endtask

  task automatic wait_b();
    int guard = 0;
    while (s_axil.bvalid && guard < 20) begin
      tick();
      guard++;
    end
    chk("b_drained", s_axil.bvalid, 0);
  endtask

  task automatic wait_r();
    int guard = 0;
    while (s_axil.rvalid && guard < 20) begin
      tick();
      guard++;
    end
    chk("r_drained", s_axil.rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    b2b_addr = '{32'h10, 32'h20, 32'h30};
    b2b_data = '{32'hDEADBEEF, 32'h11223344, 32'hFFFFABFF};

    s_axil.awaddr = '0; s_axil.awprot = '0; s_axil.awvalid = 1'b0;
    s_axil.wdata  = '0; s_axil.wstrb  = '0; s_axil.wvalid  = 1'b0;
    s_axil.bready = 1'b1;
    s_axil.araddr = '0; s_axil.arprot = '0; s_axil.arvalid = 1'b0;
    s_axil.rready = 1'b1;

    repeat (3) tick();
    chk("rst_awready", s_axil.awready, 0);
    chk("rst_wready",  s_axil.wready,  0);
    chk("rst_arready", s_axil.arready, 0);
    chk("rst_bvalid",  s_axil.bvalid,  0);
    chk("rst_rvalid",  s_axil.rvalid,  0);
    chk("rst_bresp",   s_axil.bresp,   0);
    chk("rst_rresp",   s_axil.rresp,   0);
    chk("rst_rdata",   s_axil.rdata,   0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("awready_before_first_edge", s_axil.awready, 0);
    tick();
    chk("awready_after_release", s_axil.awready, 1);
    chk("wready_after_release",  s_axil.wready,  1);
    chk("arready_after_release", s_axil.arready, 1);

    // Same-cycle AW+W, then readback.
    axil_write(32'h10, 32'hDEADBEEF, 4'hF, AXIL_RESP_OKAY, 0);
    wait_b();
    axil_read(32'h10, 32'hDEADBEEF, AXIL_RESP_OKAY, 1);
    wait_r();

    // W leads AW by three cycles.
    axil_write(32'h20, 32'h11223344, 4'hF, AXIL_RESP_OKAY, 3);
    wait_b();
    axil_read(32'h20, 32'h11223344, AXIL_RESP_OKAY, 1);
    wait_r();

    // Partial strobe merges into existing word.
    axil_write(32'h30, 32'hFFFFFFFF, 4'hF, AXIL_RESP_OKAY, 0);
    wait_b();
    axil_write(32'h30, 32'h0000AB00, 4'h2, AXIL_RESP_OKAY, 0);
    wait_b();
    axil_read(32'h30, 32'hFFFFABFF, AXIL_RESP_OKAY, 1);
    wait_r();

    // Out of range: word 1024 must not alias onto word 0.
    axil_write(32'h0, 32'hCAFEF00D, 4'hF, AXIL_RESP_OKAY, 0);
    wait_b();
    axil_write(32'h1000, 32'h12345678, 4'hF, AXIL_RESP_SLVERR, 0);
    wait_b();
    axil_read(32'h1000, 32'h0, AXIL_RESP_SLVERR, 1);
    wait_r();
    axil_read(32'h0, 32'hCAFEF00D, AXIL_RESP_OKAY, 1);
    wait_r();

    // Zero strobe is a no-op; low address bits are ignored.
    axil_write(32'h10, 32'h0, 4'h0, AXIL_RESP_OKAY, 0);
    wait_b();
    axil_read(32'h13, 32'hDEADBEEF, AXIL_RESP_OKAY, 1);
    wait_r();

    // B held by bready=0.
    s_axil.bready = 1'b0;
    axil_write(32'h2000, 32'h55AA55AA, 4'hF, AXIL_RESP_SLVERR, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bvalid_held",  s_axil.bvalid,  1);
      chk("bresp_held",   s_axil.bresp,   2'b10);
      chk("awready_held", s_axil.awready, 0);
      chk("wready_held",  s_axil.wready,  0);
      tick();
    end
    s_axil.bready = 1'b1;
    tick();
    chk("bvalid_after_hs",  s_axil.bvalid,  0);
    chk("awready_after_hs", s_axil.awready, 1);
    axil_write(32'h40, 32'h01010101, 4'hF, AXIL_RESP_OKAY, 0);
    wait_b();

    // Same-edge read and write of one word: read sees old data.
    b_q.push_back(AXIL_RESP_OKAY);
    r_data_q.push_back(32'h01010101);
    r_resp_q.push_back(AXIL_RESP_OKAY);
    $display("AW+AR collide addr=0x00000040 data=0x02020202");
    s_axil.awaddr = 32'h40; s_axil.wdata = 32'h02020202; s_axil.wstrb = 4'hF;
    s_axil.araddr = 32'h40;
    s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1; s_axil.arvalid = 1'b1;
    @(negedge clk);
    chk("collide_readies", {s_axil.awready, s_axil.wready, s_axil.arready}, 3'b111);
    tick();
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0; s_axil.arvalid = 1'b0;
    chk("collide_bvalid", s_axil.bvalid, 1);
    chk("collide_rvalid", s_axil.rvalid, 1);
    wait_b();
    wait_r();
    axil_read(32'h40, 32'h02020202, AXIL_RESP_OKAY, 1);
    wait_r();

    // Back-to-back reads, one per cycle.
    for (int i = 0; i < 3; i++) begin
      r_data_q.push_back(b2b_data[i]);
      r_resp_q.push_back(AXIL_RESP_OKAY);
    end
    s_axil.arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axil.araddr = b2b_addr[i];
      $display("AR  addr=0x%08h (burst)", b2b_addr[i]);
      @(negedge clk);
      chk("b2b_arready", s_axil.arready, 1);
      tick();
    end
    s_axil.arvalid = 1'b0;
    wait_r();

    // Reset while an R is stalled.
    s_axil.rready = 1'b0;
    axil_read(32'h10, 32'hDEADBEEF, AXIL_RESP_OKAY, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rvalid_stalled", s_axil.rvalid, 1);
      chk("rdata_stalled",  s_axil.rdata,  32'hDEADBEEF);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rvalid",  s_axil.rvalid,  0);
    chk("mid_rst_rdata",   s_axil.rdata,   0);
    chk("mid_rst_arready", s_axil.arready, 0);
    chk("mid_rst_awready", s_axil.awready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arready_pre_edge", s_axil.arready, 0);
    tick();
    chk("arready_first_edge", s_axil.arready, 1);
    s_axil.rready = 1'b1;
    axil_read(32'h10, 32'hDEADBEEF, AXIL_RESP_OKAY, 1);
    wait_r();

    tick();
    chk("b_queue_empty", b_q.size(), 0);
    chk("r_queue_empty", r_data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
